// File: rtl/timer_irq_ctrl.sv
// -----------------------------------------------------------------------------
// timer_irq_ctrl
//   Interrupt/status stage for timer_counter_8bit. It detects rising edges on
//   the timer's overflow/underflow levels and latches them into sticky
//   write-1-to-clear flags. Per-source enables combine the flags into a single
//   registered interrupt. There is an APB slave with zero wait states.
//
//   Build option: define TIMER_IRQ_CNT_EN to implement the OVF_CNT/UDF_CNT
//   saturating event counters at 3'h2/3'h3. When it is not defined, those
//   addresses decode as unmapped.
//
//   Register map
//     3'h0 TSR      [1] UDF_F, [0] OVF_F  (W1C, set wins over clear)
//     3'h1 TIER     [1] UDF_IE, [0] OVF_IE
//     3'h2 OVF_CNT  saturating edge count, any write clears  (optional)
//     3'h3 UDF_CNT  saturating edge count, any write clears  (optional)
//
//   Ports
//     pclk, preset          clock, synchronous active-high reset
//     psel, penable, pwrite APB control
//     paddr, pwdata         APB address / write data
//     prdata, pready,       APB read data / ready / error (combinational)
//     pslverr
//     tmr_ovf, tmr_udf      pclk-synchronous timer levels
//     irq                   registered interrupt request
// -----------------------------------------------------------------------------
module timer_irq_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr,
  input  logic                  tmr_ovf,
  input  logic                  tmr_udf,
  output logic                  irq
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_TSR     = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] ADDR_TIER    = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_OVF_CNT = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] ADDR_UDF_CNT = ADDR_WIDTH'(3);

  logic       access;
  logic       wr_en;
  logic       mapped;
  logic       ovf_q;
  logic       udf_q;
  logic       ovf_ev;
  logic       udf_ev;
  logic [1:0] tsr_q;
  logic [1:0] tier_q;
  logic [1:0] tsr_clr;
  logic [1:0] tsr_set;
  logic [DATA_WIDTH-1:0] rd_val;

  assign access = psel & penable;
  assign wr_en  = access & pwrite & mapped;

  assign ovf_ev = tmr_ovf & ~ovf_q;
  assign udf_ev = tmr_udf & ~udf_q;

  assign tsr_set = {udf_ev, ovf_ev};
  assign tsr_clr = (wr_en && paddr == ADDR_TSR) ? pwdata[1:0] : 2'b00;

  always_ff @(posedge pclk) begin
    if (preset) begin
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
      tsr_q  <= '0;
      tier_q <= '0;
      irq    <= 1'b0;
    end else begin
      ovf_q <= tmr_ovf;
      udf_q <= tmr_udf;
      // Set is OR'd in after the clear, so a same-cycle event survives.
      tsr_q <= (tsr_q & ~tsr_clr) | tsr_set;
      if (wr_en && paddr == ADDR_TIER) begin
        tier_q <= pwdata[1:0];
      end
      irq <= |(tsr_q & tier_q);
    end
  end

`ifdef TIMER_IRQ_CNT_EN
  logic [7:0] ovf_cnt_q;
  logic [7:0] udf_cnt_q;

  always_ff @(posedge pclk) begin
    if (preset) begin
      ovf_cnt_q <= '0;
      udf_cnt_q <= '0;
    end else begin
      // A clearing write together with a new edge leaves a count of 1.
      if (wr_en && paddr == ADDR_OVF_CNT) begin
        ovf_cnt_q <= {7'b0, ovf_ev};
      end else if (ovf_ev && ovf_cnt_q != '1) begin
        ovf_cnt_q <= ovf_cnt_q + 8'd1;
      end
      if (wr_en && paddr == ADDR_UDF_CNT) begin
        udf_cnt_q <= {7'b0, udf_ev};
      end else if (udf_ev && udf_cnt_q != '1) begin
        udf_cnt_q <= udf_cnt_q + 8'd1;
      end
    end
  end

  always_comb begin
    mapped = 1'b0;
    rd_val = '0;
    case (paddr)
      ADDR_TSR: begin
        mapped = 1'b1;
        rd_val = {{(DATA_WIDTH-2){1'b0}}, tsr_q};
      end
      ADDR_TIER: begin
        mapped = 1'b1;
        rd_val = {{(DATA_WIDTH-2){1'b0}}, tier_q};
      end
      ADDR_OVF_CNT: begin
        mapped = 1'b1;
        rd_val = ovf_cnt_q;
      end
      ADDR_UDF_CNT: begin
        mapped = 1'b1;
        rd_val = udf_cnt_q;
      end
      default: begin
        mapped = 1'b0;
        rd_val = '0;
      end
    endcase
  end
`else
  always_comb begin
    mapped = 1'b0;
    rd_val = '0;
    case (paddr)
      ADDR_TSR: begin
        mapped = 1'b1;
        rd_val = {{(DATA_WIDTH-2){1'b0}}, tsr_q};
      end
      ADDR_TIER: begin
        mapped = 1'b1;
        rd_val = {{(DATA_WIDTH-2){1'b0}}, tier_q};
      end
      default: begin
        mapped = 1'b0;
        rd_val = '0;
      end
    endcase
  end
`endif

  assign pready  = access;
  assign pslverr = access & ~mapped;
  assign prdata  = (access && !pwrite && mapped) ? rd_val : '0;

endmodule

// File: tb/tb_timer_irq_ctrl.sv
module tb_timer_irq_ctrl;

  logic       pclk = 1'b0;
  logic       preset;
  logic       psel;
  logic       penable;
  logic       pwrite;
  logic [2:0] paddr;
  logic [7:0] pwdata;
  logic [7:0] prdata;
  logic       pready;
  logic       pslverr;
  logic       tmr_ovf;
  logic       tmr_udf;
  logic       irq;

  int n_pass  = 0;
  int n_total = 0;

  timer_irq_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) dut (
    .pclk    (pclk),
    .preset  (preset),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .prdata  (prdata),
    .pready  (pready),
    .pslverr (pslverr),
    .tmr_ovf (tmr_ovf),
    .tmr_udf (tmr_udf),
    .irq     (irq)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic [2:0] addr;
    logic [7:0] exp_data;
    logic       exp_err;
  } rd_vec_t;

  rd_vec_t vecs[8];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %02h expected %02h", name, act, exp);
  endtask

  // Ends #1 after the commit edge with the bus idle again.
  task automatic apb_write(input logic [2:0] a, input logic [7:0] d);
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    @(negedge pclk);
    penable = 1'b1;
    @(posedge pclk);
    #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [2:0] a, output logic [7:0] d,
                          output logic err, output logic rdy);
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    @(negedge pclk);
    penable = 1'b1;
    #1;
    d = prdata; err = pslverr; rdy = pready;
    @(posedge pclk);
    #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [2:0] a,
                            input logic [7:0] exp_d, input logic exp_e);
    logic [7:0] d;
    logic e, r;
    apb_read(a, d, e, r);
    check({name, " data"}, d, exp_d);
    check({name, " pslverr"}, {7'b0, e}, {7'b0, exp_e});
    check({name, " pready"}, {7'b0, r}, 8'h01);
  endtask

  task automatic step_check_irq(input string name, input logic exp);
    @(posedge pclk);
    #1;
    check(name, {7'b0, irq}, {7'b0, exp});
  endtask

  initial begin
    preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; tmr_ovf = 1'b0; tmr_udf = 1'b0;

    for (int unsigned i = 0; i < 8; i++) begin
      vecs[i].addr     = 3'(i);
      vecs[i].exp_data = 8'h00;
      vecs[i].exp_err  = (i >= 4);
    end
`ifndef TIMER_IRQ_CNT_EN
    vecs[2].exp_err = 1'b1;
    vecs[3].exp_err = 1'b1;
`endif

    repeat (2) @(posedge pclk);
    #1;
    check("reset irq", {7'b0, irq}, 8'h00);
    check("reset pready", {7'b0, pready}, 8'h00);
    check("reset pslverr", {7'b0, pslverr}, 8'h00);
    check("reset prdata", prdata, 8'h00);
    @(negedge pclk);
    preset = 1'b0;

    for (int unsigned i = 0; i < 8; i++) begin
      read_check($sformatf("reset read a%0d", i), vecs[i].addr,
                 vecs[i].exp_data, vecs[i].exp_err);
    end

    // Unused TIER bits are ignored.
    apb_write(3'h1, 8'hFC);
    read_check("tier upper bits", 3'h1, 8'h00, 1'b0);

    // OVF event with OVF_IE set: irq two edges after the rise.
    apb_write(3'h1, 8'h01);
    @(negedge pclk);
    tmr_ovf = 1'b1;
    step_check_irq("ovf irq edge N", 1'b0);
    step_check_irq("ovf irq edge N+1", 1'b1);
    @(negedge pclk);
    @(negedge pclk);
    tmr_ovf = 1'b0;
    read_check("tsr after ovf", 3'h0, 8'h01, 1'b0);
`ifdef TIMER_IRQ_CNT_EN
    read_check("ovf_cnt one level", 3'h2, 8'h01, 1'b0);
`endif
    apb_write(3'h0, 8'h00);
    read_check("tsr write0 no effect", 3'h0, 8'h01, 1'b0);
    apb_write(3'h0, 8'h01);
    step_check_irq("ovf clear irq", 1'b0);

    // UDF event masked, then enabled, then cleared.
    @(negedge pclk);
    tmr_udf = 1'b1;
    @(negedge pclk);
    tmr_udf = 1'b0;
    step_check_irq("udf masked irq", 1'b0);
    read_check("tsr after udf", 3'h0, 8'h02, 1'b0);
    check("udf masked irq later", {7'b0, irq}, 8'h00);
    apb_write(3'h1, 8'h02);
    check("tier commit irq still 0", {7'b0, irq}, 8'h00);
    step_check_irq("tier enable irq", 1'b1);
    apb_write(3'h0, 8'h02);
    check("tsr clr commit irq still 1", {7'b0, irq}, 8'h01);
    step_check_irq("udf clear irq", 1'b0);

    // Event and W1C in the same cycle: set wins.
    apb_write(3'h1, 8'h01);
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 3'h0; pwdata = 8'h01;
    @(negedge pclk);
    penable = 1'b1;
    tmr_ovf = 1'b1;
    @(posedge pclk);
    #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    step_check_irq("set wins irq", 1'b1);
    @(negedge pclk);
    tmr_ovf = 1'b0;
    read_check("set wins tsr", 3'h0, 8'h01, 1'b0);
    apb_write(3'h0, 8'h01);

`ifdef TIMER_IRQ_CNT_EN
    read_check("ovf_cnt two", 3'h2, 8'h02, 1'b0);
    for (int unsigned i = 0; i < 300; i++) begin
      @(negedge pclk);
      tmr_udf = 1'b1;
      @(negedge pclk);
      tmr_udf = 1'b0;
    end
    read_check("udf_cnt saturates", 3'h3, 8'hFF, 1'b0);
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 3'h3; pwdata = 8'h55;
    @(negedge pclk);
    penable = 1'b1;
    tmr_udf = 1'b1;
    @(posedge pclk);
    #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    @(negedge pclk);
    tmr_udf = 1'b0;
    read_check("udf_cnt write+edge", 3'h3, 8'h01, 1'b0);
    apb_write(3'h2, 8'h00);
    read_check("ovf_cnt cleared", 3'h2, 8'h00, 1'b0);
    apb_write(3'h0, 8'h03);
`else
    apb_write(3'h2, 8'h5A);
    read_check("cnt2 unmapped", 3'h2, 8'h00, 1'b1);
    read_check("cnt3 unmapped", 3'h3, 8'h00, 1'b1);
`endif
    apb_write(3'h5, 8'hFF);
    read_check("tier after unmapped wr", 3'h1, 8'h01, 1'b0);

    // Reset mid TIER write while irq is high; udf held high through reset.
    @(negedge pclk);
    tmr_ovf = 1'b1;
    step_check_irq("pre-reset flag", 1'b0);
    step_check_irq("pre-reset irq", 1'b1);
    @(negedge pclk);
    tmr_ovf = 1'b0;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 3'h1; pwdata = 8'h03;
    @(negedge pclk);
    penable = 1'b1;
    preset = 1'b1;
    tmr_udf = 1'b1;
    @(posedge pclk);
    #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    check("reset mid write irq", {7'b0, irq}, 8'h00);
    @(negedge pclk);
    preset = 1'b0;
    read_check("tier after reset", 3'h1, 8'h00, 1'b0);
    read_check("tsr high at release", 3'h0, 8'h02, 1'b0);
    check("irq after reset", {7'b0, irq}, 8'h00);
    tmr_udf = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/timer_irq_ctrl.md
# timer_irq_ctrl

Interrupt/status stage directly downstream of `timer_counter_8bit`. It detects rising edges on the timer's `TMR_OVF` / `TMR_UDF` outputs and latches them into sticky write-1-to-clear flags. Per-source enables gate the flags into a single registered interrupt line. An APB slave port on the same bus exposes the flags, enables and optional event counters.

## Interface
Parameters:
- `DATA_WIDTH`, 8: APB data width. Only 8 is supported.
- `ADDR_WIDTH`, 3: APB address width.

Ports:
- `pclk`  in  1  bus/system clock; all logic is on its rising edge.
- `preset`  in  1  **synchronous, active-high** reset.
- `psel`  in  1  APB select.
- `penable`  in  1  APB access phase.
- `pwrite`  in  1  1 = write, 0 = read.
- `paddr`  in  ADDR_WIDTH  register address.
- `pwdata`  in  DATA_WIDTH  write data.
- `prdata`  out  DATA_WIDTH  read data.
- `pready`  out  1  transfer complete.
- `pslverr`  out  1  transfer error.
- `tmr_ovf`  in  1  overflow level from the timer, pclk-synchronous.
- `tmr_udf`  in  1  underflow level from the timer, pclk-synchronous.
- `irq`  out  1  registered interrupt request.

## Operation
Register map:
- 3'h0 TSR: bit0 OVF_F, bit1 UDF_F. Write 1 to clear a flag; writing 0 has no effect. Bits [7:2] read 0.
- 3'h1 TIER: bit0 OVF_IE, bit1 UDF_IE. Read/write. Bits [7:2] are ignored on write and read 0.
- 3'h2 OVF_CNT: 8-bit saturating count of OVF edges. A write of any value clears it to 0.
- 3'h3 UDF_CNT: same as OVF_CNT, for UDF edges.
- 3'h4–3'h7: unmapped. Behaviour is given under the APB rules below.

Edge detect:
- `ovf_q` and `udf_q` register the inputs every cycle.
- `ovf_ev = tmr_ovf & ~ovf_q` and `udf_ev = tmr_udf & ~udf_q`.
- A level held high produces exactly one event.

Flags:
- A flag is set by its event.
- A flag is cleared by a TSR write with the corresponding `pwdata` bit = 1.
- If an event and a clear hit the same cycle, **set wins**.

Counters:
- Each event increments its counter. At 8'hFF the counter holds (no wrap).
- If an event and a counter write hit the same cycle, the counter becomes 8'h01.

Interrupt:
- `irq` is registered: `irq <= |(TSR[1:0] & TIER[1:0])`.

APB rules:
- Access phase = `psel & penable`.
- `pready` = 1 in every access phase, so there are zero wait states. It is 0 outside access phase.
- Writes commit on the rising edge that ends the access phase.
- `prdata` is combinational: the register value during a read access phase, 8'h00 otherwise.
- `pslverr` = 1 during the access phase for unmapped addresses. For these, writes are dropped and reads return 8'h00.

## Timing
- Reset values: `prdata`=0, `pready`=0, `pslverr`=0, `irq`=0. Also TSR=0, TIER=0, both counters 0, `ovf_q`=`udf_q`=0.
- Because `ovf_q` resets to 0, an input that is already high at reset release yields one event on the first cycle after release.
- Event latency: input rises before edge N. The flag and counter are updated at edge N. `irq` asserts at edge N+1.
- Clear latency: a TSR W1C commits at edge N. `irq` deasserts at edge N+1, unless another enabled flag is still set.
- Enabling a flag that is already set via TIER: `irq` asserts one edge after the write commits.
- If `preset` is asserted during an APB transfer, all state is cleared at that edge and the write is discarded.
- Events arriving while `preset`=1 are ignored.

## Configuration
- `TIMER_IRQ_CNT_EN`:
  - Defined: OVF_CNT and UDF_CNT are implemented at 3'h2 and 3'h3.
  - Undefined: the counters are not synthesised. 3'h2 and 3'h3 behave as unmapped (`pslverr`=1, read 8'h00, writes dropped). Flags and `irq` are unaffected.

## Test plan
- Reset, then read all addresses. Required: 3'h0–3'h3 read 8'h00 with `pslverr`=0; 3'h4–3'h7 read 8'h00 with `pslverr`=1.
- Write TIER=8'h01. Pulse `tmr_ovf` for 3 cycles. Required: TSR reads 8'h01, OVF_CNT=8'h01, `irq`=1 two edges after the input rises.
- With UDF_IE=0, pulse `tmr_udf`. Required: TSR=8'h02 and `irq` stays 0. Then write TIER=8'h02: `irq`=1 one edge later. Then write TSR=8'h02: `irq`=0 one edge later.
- Raise `tmr_ovf` in the same cycle as a TSR write of 8'h01. Required: OVF_F remains 1.
- With `TIMER_IRQ_CNT_EN` defined: 300 `tmr_udf` pulses give UDF_CNT=8'hFF. A write to UDF_CNT coinciding with a new edge gives 8'h01. Without the macro, reading 3'h3 gives `pslverr`=1.
- Assert `preset` for 1 cycle mid-write to TIER. Required: TIER=0 afterwards and `irq`=0.
